// File: rtl/mem_access_unit.sv
// MEM-stage controller: byte/half/word loads and stores onto a word-wide memory.
// Sub-word stores read-modify-write; loads are lane-selected and extended.
module mem_access_unit #(
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_we,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_we,
  output logic [DATA_W-1:0] wb_data,
  output logic              exc_misaligned
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD_WAIT = 2'd1;
  localparam logic [1:0] RMW_WAIT  = 2'd2;

  logic [1:0]  state;
  logic        accept;
  logic        is_load;
  logic        is_store;
  logic        sz_byte;
  logic        sz_half;
  logic        sz_word;
  logic        misal;
  logic        issue_rd;
  logic        issue_sw;

  logic        l_byte;
  logic        l_half;
  logic        l_uns;
  logic [1:0]  l_off;
  logic [4:0]  l_rd;
  logic        l_we;
  logic [15:0] l_wdata;
  logic [29:0] l_word;

  logic [1:0]  bpos;
  logic        hpos;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign in_ready = (state == IDLE) & ~flush;
  assign accept   = in_valid & in_ready;
  assign is_load  = in_is_load;
  assign is_store = in_is_store & ~in_is_load;
  assign sz_byte  = (in_size == 2'b00);
  assign sz_half  = (in_size == 2'b01);
  assign sz_word  = in_size[1];

  assign misal = (is_load | is_store) &
                 ((sz_half & in_addr[0]) |
                  (sz_word & (|in_addr[1:0])));

  assign issue_rd = accept & ~misal &
                    (is_load | (is_store & ~sz_word));
  assign issue_sw = accept & ~misal & is_store & sz_word;

  // Physical lane position (0 = bits [7:0]) of the addressed byte/half.
  assign bpos = l_off ^ {2{BIG_ENDIAN}};
  assign hpos = l_off[1] ^ BIG_ENDIAN;

  always_comb begin
    byte_v   = mem_data_out[{bpos, 3'b000} +: 8];
    half_v   = hpos ? mem_data_out[31:16] : mem_data_out[15:0];
    load_val = mem_data_out;
    if (l_byte) begin
      load_val = {{24{~l_uns & byte_v[7]}}, byte_v};
    end else if (l_half) begin
      load_val = {{16{~l_uns & half_v[15]}}, half_v};
    end
  end

  always_comb begin
    merged = mem_data_out;
    for (int j = 0; j < 4; j++) begin
      if (l_byte && bpos == j[1:0]) begin
        merged[8*j +: 8] = l_wdata[7:0];
      end
      if (l_half && hpos == j[1]) begin
        merged[8*j +: 8] = j[0] ? l_wdata[15:8] : l_wdata[7:0];
      end
    end
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    if (reset_n) begin
      case (state)
        IDLE: begin
          if (issue_rd) begin
            mem_read    = 1'b1;
            mem_address = {2'b00, in_addr[31:2]};
          end
          if (issue_sw) begin
            mem_write   = 1'b1;
            mem_address = {2'b00, in_addr[31:2]};
            mem_data_in = in_wdata;
          end
        end
        RMW_WAIT: begin
          if (!flush) begin
            mem_write   = 1'b1;
            mem_address = {2'b00, l_word};
            mem_data_in = merged;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_reg_we      <= 1'b0;
      wb_data        <= '0;
      exc_misaligned <= 1'b0;
      l_byte         <= 1'b0;
      l_half         <= 1'b0;
      l_uns          <= 1'b0;
      l_off          <= '0;
      l_rd           <= '0;
      l_we           <= 1'b0;
      l_wdata        <= '0;
      l_word         <= '0;
    end else begin
      wb_valid       <= 1'b0;
      exc_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            l_byte  <= sz_byte;
            l_half  <= sz_half;
            l_uns   <= in_unsigned;
            l_off   <= in_addr[1:0];
            l_rd    <= in_rd;
            l_we    <= in_reg_we;
            l_wdata <= in_wdata[15:0];
            l_word  <= in_addr[31:2];
            if (misal) begin
              wb_valid       <= 1'b1;
              wb_rd          <= in_rd;
              wb_reg_we      <= 1'b0;
              exc_misaligned <= 1'b1;
            end else if (is_load) begin
              state <= LOAD_WAIT;
            end else if (is_store && !sz_word) begin
              state <= RMW_WAIT;
            end else if (is_store) begin
              wb_valid  <= 1'b1;
              wb_rd     <= in_rd;
              wb_reg_we <= 1'b0;
            end else begin
              wb_valid  <= 1'b1;
              wb_rd     <= in_rd;
              wb_reg_we <= in_reg_we;
              wb_data   <= in_addr;
            end
          end
        end
        LOAD_WAIT: begin
          state <= IDLE;
          if (!flush) begin
            wb_valid  <= 1'b1;
            wb_rd     <= l_rd;
            wb_reg_we <= l_we;
            wb_data   <= load_val;
          end
        end
        RMW_WAIT: begin
          state <= IDLE;
          if (!flush) begin
            wb_valid  <= 1'b1;
            wb_rd     <= l_rd;
            wb_reg_we <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model with per-cycle compare
// against a word memory device, plus literal expectations on load results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic        in_is_store;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        in_reg_we;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_we;
  logic [31:0] wb_data;
  logic        exc_misaligned;

  always #5 clk = ~clk;

  mem_access_unit #(.BIG_ENDIAN(1'b1), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rd(in_rd), .in_reg_we(in_reg_we),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
    .wb_data(wb_data), .exc_misaligned(exc_misaligned)
  );

  // Word memory device: read data valid only the cycle after mem_read.
  logic [31:0] dev_mem [16];
  logic [31:0] dev_q;
  logic        dev_v = 1'b0;

  always @(posedge clk) begin
    if (mem_write) dev_mem[mem_address[3:0]] <= mem_data_in;
    dev_v <= mem_read;
    if (mem_read) dev_q <= dev_mem[mem_address[3:0]];
  end
  assign mem_data_out = dev_v ? dev_q : 32'hA5A5_A5A5;

  typedef struct {
    bit          we;
    bit          exc;
    bit          chk_data;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          has_lit;
    logic [31:0] lit;
  } wb_t;

  logic [31:0] ref_mem [16];
  wb_t         exp_wb [int];
  bit          busy [int];
  logic [31:0] exp_ra [int];
  logic [31:0] exp_wa [int];
  logic [31:0] exp_wd [int];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Big-endian: byte 0 of a word is its most significant byte.
  function automatic logic [7:0] byte_at(input logic [31:0] w, input int k);
    return 8'(w >> (8 * (3 - k)));
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] w,
      input logic [31:0] a, input logic [1:0] sz, input bit uns);
    int k;
    logic [15:0] h;
    k = int'(a[1:0]);
    if (sz == SZ_B) begin
      h = {8'h00, byte_at(w, k)};
      return (uns || !h[7]) ? {24'h0, h[7:0]} : {24'hFFFFFF, h[7:0]};
    end
    if (sz == SZ_H) begin
      h = {byte_at(w, k), byte_at(w, k + 1)};
      return (uns || !h[15]) ? {16'h0, h} : {16'hFFFF, h};
    end
    return w;
  endfunction

  function automatic logic [31:0] store_model(input logic [31:0] w,
      input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [7:0] b [4];
    int k;
    k = int'(a[1:0]);
    for (int i = 0; i < 4; i++) b[i] = byte_at(w, i);
    if (sz == SZ_B) begin
      b[k] = wd[7:0];
    end else begin
      b[k]     = wd[15:8];
      b[k + 1] = wd[7:0];
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  // abort: 0 none, 1 flush in wait state, 2 reset in wait state,
  // 3 flush in the issue cycle.
  task automatic do_op(input bit ld, input bit st, input logic [1:0] sz,
      input bit uns, input logic [31:0] addr, input logic [31:0] wd,
      input logic [4:0] rd, input bit we, input bit has_lit,
      input logic [31:0] lit, input int abort);
    int c;
    int idx;
    bit is_ld;
    bit is_st;
    bit mis;
    bit two;
    wb_t e;
    logic [31:0] nw;
    c     = cyc;
    idx   = int'(addr[5:2]);
    is_ld = ld;
    is_st = st && !ld;
    mis   = (is_ld || is_st) &&
            ((sz == SZ_H && addr[0]) || (sz[1] && addr[1:0] != 2'b00));
    two   = 1'b0;
    in_valid = 1'b1; in_is_load = ld; in_is_store = st;
    in_size = sz; in_unsigned = uns; in_addr = addr;
    in_wdata = wd; in_rd = rd; in_reg_we = we;
    flush = (abort == 3);
    e = '{we: 1'b0, exc: 1'b0, chk_data: 1'b0, rd: rd, data: 32'h0,
          has_lit: has_lit, lit: lit};
    if (abort == 3) begin
    end else if (mis) begin
      e.exc = 1'b1;
      exp_wb[c + 1] = e;
    end else if (!is_ld && !is_st) begin
      e.we = we; e.chk_data = 1'b1; e.data = addr;
      exp_wb[c + 1] = e;
    end else if (is_st && sz[1]) begin
      exp_wa[c] = addr >> 2;
      exp_wd[c] = wd;
      ref_mem[idx] = wd;
      exp_wb[c + 1] = e;
    end else begin
      two = 1'b1;
      exp_ra[c] = addr >> 2;
      busy[c + 1] = 1'b1;
      if (abort == 0) begin
        if (is_ld) begin
          e.we = we; e.chk_data = 1'b1;
          e.data = load_model(ref_mem[idx], addr, sz, uns);
        end else begin
          nw = store_model(ref_mem[idx], addr, sz, wd);
          exp_wa[c + 1] = addr >> 2;
          exp_wd[c + 1] = nw;
          ref_mem[idx] = nw;
        end
        exp_wb[c + 2] = e;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    if (two) begin
      if (abort == 1) flush = 1'b1;
      if (abort == 2) reset_n = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      reset_n = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
      chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
      chk("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
      chk("rst_wb_rd", {27'b0, wb_rd}, 32'h0);
      chk("rst_wb_reg_we", {31'b0, wb_reg_we}, 32'h0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_exc", {31'b0, exc_misaligned}, 32'h0);
    end else begin
      chk("in_ready", {31'b0, in_ready},
          {31'b0, !busy.exists(cyc) && !flush});
      chk("mem_read", {31'b0, mem_read}, {31'b0, exp_ra.exists(cyc)});
      if (exp_ra.exists(cyc)) chk("rd_address", mem_address, exp_ra[cyc]);
      chk("mem_write", {31'b0, mem_write}, {31'b0, exp_wa.exists(cyc)});
      if (exp_wa.exists(cyc)) begin
        chk("wr_address", mem_address, exp_wa[cyc]);
        chk("wr_data", mem_data_in, exp_wd[cyc]);
      end
      chk("data_in_known", {31'b0, $isunknown(mem_data_in)}, 32'h0);
      chk("wb_valid", {31'b0, wb_valid}, {31'b0, exp_wb.exists(cyc)});
      if (wb_valid && exp_wb.exists(cyc)) begin
        chk("wb_reg_we", {31'b0, wb_reg_we}, {31'b0, exp_wb[cyc].we});
        chk("exc_misaligned", {31'b0, exc_misaligned},
            {31'b0, exp_wb[cyc].exc});
        if (exp_wb[cyc].we) chk("wb_rd", {27'b0, wb_rd},
                                {27'b0, exp_wb[cyc].rd});
        if (exp_wb[cyc].chk_data) chk("wb_data", wb_data, exp_wb[cyc].data);
        if (exp_wb[cyc].has_lit) chk("wb_lit", wb_data, exp_wb[cyc].lit);
      end
      if (!wb_valid) chk("exc_idle", {31'b0, exc_misaligned}, 32'h0);
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      dev_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_is_load = 1'b0; in_is_store = 1'b0; in_size = 2'b00;
    in_unsigned = 1'b0; in_addr = '0; in_wdata = '0;
    in_rd = '0; in_reg_we = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    // SW then LW
    do_op(0, 1, SZ_W, 0, 32'h8, 32'hDEADBEEF, 5'd0, 0, 0, 0, 0);
    do_op(1, 0, SZ_W, 0, 32'h8, 32'h0, 5'd5, 1, 1, 32'hDEADBEEF, 0);
    // byte/half selection
    do_op(0, 1, SZ_W, 0, 32'h4, 32'h11223344, 5'd0, 0, 0, 0, 0);
    do_op(1, 0, SZ_B, 0, 32'h5, 32'h0, 5'd1, 1, 1, 32'h00000022, 0);
    do_op(1, 0, SZ_B, 0, 32'h7, 32'h0, 5'd2, 1, 1, 32'h00000044, 0);
    do_op(1, 0, SZ_H, 0, 32'h6, 32'h0, 5'd3, 1, 1, 32'h00003344, 0);
    // sign/zero extension
    do_op(0, 1, SZ_W, 0, 32'h0, 32'h80FF0000, 5'd0, 0, 0, 0, 0);
    do_op(1, 0, SZ_B, 0, 32'h0, 32'h0, 5'd4, 1, 1, 32'hFFFFFF80, 0);
    do_op(1, 0, SZ_B, 1, 32'h0, 32'h0, 5'd6, 1, 1, 32'h00000080, 0);
    do_op(1, 0, SZ_H, 0, 32'h0, 32'h0, 5'd8, 1, 1, 32'hFFFF80FF, 0);
    do_op(1, 0, SZ_H, 1, 32'h0, 32'h0, 5'd9, 1, 1, 32'h000080FF, 0);
    // SB read-modify-write, upper wdata bits must be ignored
    do_op(0, 1, SZ_B, 0, 32'h6, 32'h123456AB, 5'd0, 0, 0, 0, 0);
    do_op(1, 0, SZ_W, 0, 32'h4, 32'h0, 5'd10, 1, 1, 32'h1122AB44, 0);
    // misaligned
    do_op(1, 0, SZ_H, 0, 32'h3, 32'h0, 5'd11, 1, 0, 0, 0);
    do_op(0, 1, SZ_W, 0, 32'h2, 32'h55555555, 5'd0, 0, 0, 0, 0);
    do_op(1, 0, SZ_W, 0, 32'hA, 32'h0, 5'd12, 1, 0, 0, 0);
    do_op(1, 0, SZ_W, 0, 32'h0, 32'h0, 5'd13, 1, 1, 32'h80FF0000, 0);
    // ALU pass-through, load+store treated as load
    do_op(0, 0, SZ_W, 0, 32'h12345678, 32'h0, 5'd7, 1, 1, 32'h12345678, 0);
    do_op(0, 0, SZ_B, 0, 32'hCAFEF00D, 32'h0, 5'd14, 0, 0, 0, 0);
    do_op(1, 1, SZ_B, 1, 32'h5, 32'h0, 5'd15, 1, 1, 32'h00000022, 0);
    do_op(1, 0, SZ_W, 0, 32'h4, 32'h0, 5'd16, 1, 1, 32'h1122AB44, 0);
    // SH and readback
    do_op(0, 1, SZ_H, 0, 32'h6, 32'h0000CAFE, 5'd0, 0, 0, 0, 0);
    do_op(1, 0, SZ_H, 1, 32'h6, 32'h0, 5'd17, 1, 1, 32'h0000CAFE, 0);
    do_op(1, 0, SZ_H, 0, 32'h6, 32'h0, 5'd18, 1, 1, 32'hFFFFCAFE, 0);
    do_op(1, 0, SZ_W, 0, 32'h4, 32'h0, 5'd19, 1, 1, 32'h1122CAFE, 0);
    // flush in RMW_WAIT, flush in IDLE, reset in LOAD_WAIT
    do_op(0, 1, SZ_H, 0, 32'h4, 32'h00005555, 5'd0, 0, 0, 0, 1);
    do_op(1, 0, SZ_W, 0, 32'h4, 32'h0, 5'd20, 1, 1, 32'h1122CAFE, 0);
    do_op(0, 1, SZ_W, 0, 32'h4, 32'h77777777, 5'd0, 0, 0, 0, 3);
    do_op(1, 0, SZ_W, 0, 32'h8, 32'h0, 5'd21, 1, 0, 0, 2);
    do_op(1, 0, SZ_W, 0, 32'h8, 32'h0, 5'd22, 1, 1, 32'hDEADBEEF, 0);
    do_op(1, 0, SZ_W, 0, 32'h4, 32'h0, 5'd23, 1, 1, 32'h1122CAFE, 0);
    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
